// File: rtl/rx_sequencer.sv
`timescale 1ns/1ps
// rx_sequencer: receive control for the UART-style serial receiver.
// Synchronises the line, qualifies the start bit, paces mid-bit sampling
// of the 9-bit shift register and owns the host-side status flags.
module rx_sequencer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic rx_sync,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(NUM_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECEIVE,
    STOP_CHK,
    LOAD
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, bit_cnt_n;
  logic [IW-1:0] bit_idx, bit_idx_n;
  logic          s1, rx_prev;
  logic          fe_clear, fe_set;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all three idle high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1      <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      s1      <= serial_in;
      rx_sync <= s1;
      rx_prev <= rx_sync;
    end
  end

  // State, bit-period counter and bit index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
    end
  end

  // Next-state and strobe decode; the strobe lands on the last count of
  // each bit period, which sits mid-bit because the start check ran half a bit.
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    bit_idx_n    = bit_idx;
    shift_strobe = 1'b0;
    load_buffer  = 1'b0;
    fe_clear     = 1'b0;
    fe_set       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_n   = START_CHK;
          bit_cnt_n = '0;
        end
      end
      START_CHK: begin
        if (bit_cnt == HALF_LAST) begin
          bit_cnt_n = '0;
          if (!rx_sync) begin
            state_n   = RECEIVE;
            bit_idx_n = '0;
            fe_clear  = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      RECEIVE: begin
        if (bit_cnt == BIT_LAST) begin
          shift_strobe = 1'b1;
          bit_cnt_n    = '0;
          bit_idx_n    = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_n = STOP_CHK;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      STOP_CHK: begin
        if (stop_bit) begin
          state_n = LOAD;
        end else begin
          fe_set  = 1'b1;
          state_n = IDLE;
        end
      end
      LOAD: begin
        load_buffer = 1'b1;
        state_n     = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Host flags: a load always wins over a coincident read, and an overrun is
  // only flagged when the previous byte is still unread at load time.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load_buffer) begin
        data_ready <= 1'b1;
        if (data_ready && !data_read) begin
          overrun_error <= 1'b1;
        end
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (fe_clear) begin
        framing_error <= 1'b0;
      end else if (fe_set) begin
        framing_error <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/rx_sequencer.md
Name: rx_sequencer

Overview:
- Receive control unit for the UART-style serial receiver.
- Synchronises the raw serial line, detects and qualifies the start bit, and times mid-bit sampling with an internal bit-period counter.
- Generates the shift_strobe that drives the 9-bit receive shift register (8 data bits plus stop bit), checks the returned stop bit, and manages the data-ready, framing-error and overrun flags toward the host side.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit period; must be even and >= 4.
NUM_BITS, 9, shift strobes per frame (8 data + 1 stop).

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  asynchronous active-low reset.
serial_in  input  1  raw asynchronous serial line; idle high.
stop_bit  input  1  stop-bit output of the receive shift register.
data_read  input  1  host acknowledges the buffered byte; single-cycle pulse.
rx_sync  output  1  synchronised serial line; feeds the shift register serial_in.
shift_strobe  output  1  one-cycle pulse; shift register samples rx_sync.
load_buffer  output  1  one-cycle pulse; transfer packet_data into the host buffer.
data_ready  output  1  buffered byte valid.
framing_error  output  1  last frame had stop bit = 0.
overrun_error  output  1  new byte loaded while previous byte unread.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Synchroniser: two flops, serial_in -> s1 -> rx_sync. A third flop rx_prev holds the previous rx_sync. Reset values: s1=1, rx_sync=1, rx_prev=1.
- Start edge: rx_prev=1 and rx_sync=0 while in IDLE. Call this cycle E. Edges outside IDLE are ignored.
- HALF = CLKS_PER_BIT/2. The bit counter (CLKS_PER_BIT wide range) and bit index (0..NUM_BITS) are internal.
- Reset (asynchronous, any time, including mid-frame): state=IDLE, counters=0, all outputs 0 except rx_sync=1. No strobe or load is issued after reset until a new start edge.
- IDLE: on start edge -> START_CHK with counter=0.
- START_CHK (entered E+1): counter increments each cycle. At count HALF-1 (cycle E+HALF), sample rx_sync:
  - rx_sync=0: go to RECEIVE, counter=0, bit index=0, framing_error cleared.
  - rx_sync=1: false start; go to IDLE with no output activity.
- RECEIVE: counter counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - At count CLKS_PER_BIT-1, assert shift_strobe for exactly one cycle and increment the bit index.
  - Strobe k (k=1..NUM_BITS) occurs at cycle E+HALF+k*CLKS_PER_BIT.
  - After strobe NUM_BITS, go to STOP_CHK.
  - Line glitches during RECEIVE do not alter timing.
- STOP_CHK (one cycle; stop_bit is now valid):
  - stop_bit=1: go to LOAD.
  - stop_bit=0: set framing_error, go to IDLE. No load_buffer, data_ready unchanged.
- LOAD (one cycle): assert load_buffer, go to IDLE. On the next edge, data_ready is set. If data_ready was already 1 and data_read is not asserted in this cycle, overrun_error is also set.
- data_ready clear: data_read clears it on the next edge. If LOAD and data_read coincide, data_ready remains 1 (the set wins) and no overrun is flagged.
- overrun_error clear: cleared by data_read (when not coinciding with LOAD).
- framing_error: persists until the next qualified start bit.
- busy: combinational decode of state != IDLE.
- Back-to-back frames: a new start edge is accepted in the first IDLE cycle after LOAD/STOP_CHK. rx_prev must see a high-to-low transition, so the stop bit's high level re-arms detection.
- shift_strobe and load_buffer are never asserted in the same cycle. shift_strobe is never asserted outside RECEIVE.

Test Plan:
- Reset/idle: hold n_rst=0, toggle serial_in -> all outputs 0, rx_sync=1, busy=0. Release with the line high -> no activity for 200 cycles.
- Good frame, CLKS_PER_BIT=10, byte 0xA5 LSB-first, stop=1:
  - Exactly 9 shift_strobe pulses at E+15, E+25, ..., E+95.
  - STOP_CHK at E+96, load_buffer at E+97, data_ready=1 at E+98.
  - framing_error=0.
- False start: serial_in low for 3 cycles then high -> START_CHK sample sees 1, return to IDLE, zero strobes, busy high for exactly HALF cycles.
- Framing error: valid frame with stop=0 -> 9 strobes, framing_error=1, no load_buffer, data_ready unchanged. The next good frame clears framing_error at its start qualification.
- Overrun: two good frames with no data_read -> overrun_error=1 after the second LOAD. data_read then clears data_ready and overrun_error.
- Mid-frame reset: assert n_rst after strobe 4 -> immediate IDLE, no further strobes. The next full frame is received correctly. data_read coincident with LOAD -> data_ready stays 1, overrun_error stays 0.
